// File: rtl/seq_shifter.sv
// Serial shifter: logical/arithmetic/rotate, one bit position per clock.
// Latency: done pulses n+2 cycles after an accepted start; o holds until the next done.
// Backpressure: start is honoured only while idle; starts seen while busy or done are dropped.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int NW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] i,
  input  logic [NW-1:0]    n,
  input  logic             ar,
  input  logic             lr,
  input  logic             rot,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] w, w_step;
  logic [NW-1:0]    cnt;
  logic             mode_l, mode_r, mode_a;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Rotate outranks the arithmetic flag; mode_a is already cleared for left/rotate.
  always_comb begin
    w_step = w;
    case ({mode_r, mode_l})
      2'b11:   w_step = {w[WIDTH-2:0], w[WIDTH-1]};
      2'b10:   w_step = {w[0], w[WIDTH-1:1]};
      2'b01:   w_step = {w[WIDTH-2:0], 1'b0};
      default: w_step = {(mode_a ? w[WIDTH-1] : 1'b0), w[WIDTH-1:1]};
    endcase
  end

  // o is loaded on the edge entering DONE so it is valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      w      <= '0;
      cnt    <= '0;
      o      <= '0;
      mode_l <= 1'b0;
      mode_r <= 1'b0;
      mode_a <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          w      <= i;
          cnt    <= n;
          mode_l <= lr;
          mode_r <= rot;
          mode_a <= ar & ~lr & ~rot;
        end
        SHIFT: begin
          if (cnt != '0) begin
            w   <= w_step;
            cnt <= cnt - NW'(1);
          end else begin
            o <= w;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
